// File: rtl/cvxif_instr_pkg.sv
// Shared types and constants for the CV-X-IF dot-product engine.
package cvxif_instr_pkg;

  localparam int unsigned DOT_NB_REGS      = 151;
  localparam int unsigned DOT_DATA_W       = 8;
  localparam int unsigned DOT_LANES        = 8;
  localparam int unsigned DOT_ACC_W        = 32;
  localparam int unsigned DOT_ID_W         = 3;
  localparam int unsigned DOT_LEN_W        = $clog2(DOT_NB_REGS + 1);
  localparam int unsigned DOT_DRAIN_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOAD,
    MAC,
    DRAIN,
    RESULT
  } dot_state_e;

  typedef struct packed {
    logic [DOT_LEN_W-1:0] len;
    logic [DOT_ACC_W-1:0] bias;
    logic [DOT_ID_W-1:0]  id;
  } dot_job_t;

  // Number of LANES-wide beats needed to cover len elements.
  function automatic int unsigned dot_beats(input int unsigned len, input int unsigned lanes);
    return (len + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/cvxif_dot_engine_if.sv
// Handshake/bus bundle between the load-capture/issue side and the dot-product engine.
interface cvxif_dot_engine_if
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned DATA_W = DOT_DATA_W,
  parameter int unsigned ACC_W  = DOT_ACC_W,
  parameter int unsigned ID_W   = DOT_ID_W,
  parameter int unsigned LEN_W  = DOT_LEN_W
);
  logic              clear_i;
  logic              wr_valid_i;
  logic              wr_is_weight_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              start_valid_i;
  logic              start_ready_o;
  logic [LEN_W-1:0]  start_len_i;
  logic [ACC_W-1:0]  start_bias_i;
  logic [ID_W-1:0]   start_id_i;
  logic              kill_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [ACC_W-1:0]  res_data_o;
  logic [ID_W-1:0]   res_id_o;
  logic              busy_o;
  logic              ovf_o;

  modport master (
    output clear_i, wr_valid_i, wr_is_weight_i, wr_data_i,
    output start_valid_i, start_len_i, start_bias_i, start_id_i,
    output kill_i, res_ready_i,
    input  start_ready_o, res_valid_o, res_data_o, res_id_o, busy_o, ovf_o
  );

  modport slave (
    input  clear_i, wr_valid_i, wr_is_weight_i, wr_data_i,
    input  start_valid_i, start_len_i, start_bias_i, start_id_i,
    input  kill_i, res_ready_i,
    output start_ready_o, res_valid_o, res_data_o, res_id_o, busy_o, ovf_o
  );
endinterface

// File: rtl/cvxif_operand_bank.sv
// One operand bank: append-only write pointer, sticky overflow, flush, and a LANES-wide
// extended read window starting at rd_base (entries past NB_REGS read as zero).
module cvxif_operand_bank #(
  parameter int unsigned NB_REGS = 151,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LANES   = 8,
  parameter int unsigned IDX_W   = 9,
  parameter int unsigned PTR_W   = $clog2(NB_REGS + 1),
  parameter bit          SIGNED  = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_all,
  input  logic                         clear_data,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [IDX_W-1:0]             rd_base,
  output logic [LANES-1:0][DATA_W:0]   rd_data,
  output logic [PTR_W-1:0]             ptr,
  output logic                         ovf
);
  localparam int unsigned      ADDR_W = (NB_REGS > 1) ? $clog2(NB_REGS) : 1;
  localparam logic [PTR_W-1:0] FULL   = PTR_W'(NB_REGS);

  logic [DATA_W-1:0] mem [NB_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NB_REGS; i++) mem[i] <= '0;
      ptr <= '0;
      ovf <= 1'b0;
    end else if (clear_all || clear_data) begin
      // A flush always wins over a same-cycle write; only a full clear drops ovf.
      for (int unsigned i = 0; i < NB_REGS; i++) mem[i] <= '0;
      ptr <= '0;
      if (clear_all) ovf <= 1'b0;
    end else if (wr_en) begin
      if (ptr == FULL) begin
        ovf <= 1'b1;
      end else begin
        mem[ADDR_W'(ptr)] <= wr_data;
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if ((rd_base + IDX_W'(k)) < IDX_W'(NB_REGS)) begin
        rd_data[k] = {SIGNED & mem[ADDR_W'(rd_base + IDX_W'(k))][DATA_W-1],
                      mem[ADDR_W'(rd_base + IDX_W'(k))]};
      end
    end
  end

endmodule

// File: rtl/cvxif_dot_engine.sv
// Time-multiplexed dot-product engine: bias + sum(x[i]*w[i]) over LANES multipliers per beat.
// Define CVXIF_DOT_SAT_EN for a sticky signed-saturating accumulate instead of wrap-around.
module cvxif_dot_engine
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned NB_REGS = DOT_NB_REGS,
  parameter int unsigned DATA_W  = DOT_DATA_W,
  parameter int unsigned LANES   = DOT_LANES,
  parameter int unsigned ACC_W   = DOT_ACC_W,
  parameter int unsigned ID_W    = DOT_ID_W
) (
  input logic               clk_i,
  input logic               rst_ni,
  cvxif_dot_engine_if.slave dot
);
  localparam int unsigned LEN_W   = $clog2(NB_REGS + 1);
  localparam int unsigned IDX_W   = $clog2(NB_REGS + LANES + 1);
  localparam int unsigned EXT_W   = DATA_W + 1;
  localparam int unsigned PROD_W  = 2 * DATA_W + 2;
  localparam int unsigned SUM_W   = PROD_W + $clog2(LANES + 1);
  localparam int unsigned BEAT_W  = $clog2(NB_REGS / LANES + 2);
  localparam int unsigned DRAIN_W = $clog2(DOT_DRAIN_CYCLES + 1);

  dot_state_e state_q, state_d;
  dot_job_t   job_q;

  logic [BEAT_W-1:0]         beat_q, last_beat_q;
  logic [DRAIN_W-1:0]        drain_q;
  logic [ACC_W-1:0]          acc_q, acc_next;
  logic                      p_valid_q;
  logic signed [PROD_W-1:0]  prod_d [LANES];
  logic signed [PROD_W-1:0]  prod_q [LANES];
  logic signed [SUM_W-1:0]   lane_sum;
  logic [LEN_W-1:0]          ptr_x, ptr_w;
  logic                      ovf_x, ovf_w;
  logic [LANES-1:0][EXT_W-1:0] x_lanes, w_lanes;
  logic [IDX_W-1:0]          rd_base;
  logic                      start_hs, res_hs, kill_act;

  assign start_hs = dot.start_valid_i && (state_q == IDLE);
  assign kill_act = dot.kill_i && (state_q != IDLE);
  assign res_hs   = (state_q == RESULT) && dot.res_ready_i && !kill_act;
  assign rd_base  = IDX_W'(beat_q) * IDX_W'(LANES);

  cvxif_operand_bank #(
    .NB_REGS (NB_REGS),
    .DATA_W  (DATA_W),
    .LANES   (LANES),
    .IDX_W   (IDX_W),
    .PTR_W   (LEN_W),
    .SIGNED  (1'b0)
  ) u_xbank (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .clear_all  (dot.clear_i),
    .clear_data (res_hs),
    .wr_en      (dot.wr_valid_i && !dot.wr_is_weight_i),
    .wr_data    (dot.wr_data_i),
    .rd_base    (rd_base),
    .rd_data    (x_lanes),
    .ptr        (ptr_x),
    .ovf        (ovf_x)
  );

  cvxif_operand_bank #(
    .NB_REGS (NB_REGS),
    .DATA_W  (DATA_W),
    .LANES   (LANES),
    .IDX_W   (IDX_W),
    .PTR_W   (LEN_W),
    .SIGNED  (1'b1)
  ) u_wbank (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .clear_all  (dot.clear_i),
    .clear_data (res_hs),
    .wr_en      (dot.wr_valid_i && dot.wr_is_weight_i),
    .wr_data    (dot.wr_data_i),
    .rd_base    (rd_base),
    .rd_data    (w_lanes),
    .ptr        (ptr_w),
    .ovf        (ovf_w)
  );

  // Lanes past the job length contribute nothing, even if the bank holds data there.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      prod_d[k] = PROD_W'($signed(x_lanes[k])) * PROD_W'($signed(w_lanes[k]));
      if ((rd_base + IDX_W'(k)) >= IDX_W'(job_q.len)) prod_d[k] = '0;
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + SUM_W'(prod_q[k]);
    end
  end

`ifdef CVXIF_DOT_SAT_EN
  localparam int unsigned WIDE_W = ACC_W + 1;
  logic                     sat_q;
  logic                     sat_hit;
  logic signed [WIDE_W-1:0] acc_wide;

  // Once a job has clipped, later beats leave the accumulator pinned at the limit.
  always_comb begin
    acc_wide = WIDE_W'($signed(acc_q)) + WIDE_W'(lane_sum);
    sat_hit  = 1'b0;
    acc_next = acc_wide[ACC_W-1:0];
    if (sat_q) begin
      acc_next = acc_q;
    end else if (acc_wide[ACC_W] != acc_wide[ACC_W-1]) begin
      sat_hit  = 1'b1;
      acc_next = acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  always_comb acc_next = acc_q + ACC_W'(lane_sum);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (dot.start_valid_i) state_d = (dot.start_len_i == '0) ? RESULT : WAIT_LOAD;
      WAIT_LOAD: if ((ptr_x >= LEN_W'(job_q.len)) && (ptr_w >= LEN_W'(job_q.len))) state_d = MAC;
      MAC:       if (beat_q == last_beat_q) state_d = DRAIN;
      DRAIN:     if (drain_q == DRAIN_W'(DOT_DRAIN_CYCLES - 1)) state_d = RESULT;
      RESULT:    if (dot.res_ready_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (kill_act) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      job_q       <= '0;
      beat_q      <= '0;
      last_beat_q <= '0;
      drain_q     <= '0;
      acc_q       <= '0;
      p_valid_q   <= 1'b0;
      for (int unsigned k = 0; k < LANES; k++) prod_q[k] <= '0;
`ifdef CVXIF_DOT_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      p_valid_q <= (state_q == MAC) && !kill_act;
      drain_q   <= (state_q == DRAIN) ? drain_q + DRAIN_W'(1) : '0;
      if (state_q == MAC) begin
        prod_q <= prod_d;
        beat_q <= beat_q + BEAT_W'(1);
      end
      if (start_hs) begin
        job_q <= '{len:  DOT_LEN_W'(dot.start_len_i),
                   bias: DOT_ACC_W'(dot.start_bias_i),
                   id:   DOT_ID_W'(dot.start_id_i)};
        acc_q       <= dot.start_bias_i;
        last_beat_q <= BEAT_W'(dot_beats(32'(dot.start_len_i), LANES) - 1);
`ifdef CVXIF_DOT_SAT_EN
        sat_q       <= 1'b0;
`endif
      end else if ((state_q == WAIT_LOAD) && (state_d == MAC)) begin
        beat_q <= '0;
        acc_q  <= ACC_W'(job_q.bias);
      end else if (p_valid_q && !kill_act) begin
        acc_q <= acc_next;
`ifdef CVXIF_DOT_SAT_EN
        sat_q <= sat_q | sat_hit;
`endif
      end
    end
  end

  assign dot.start_ready_o = (state_q == IDLE);
  assign dot.busy_o        = (state_q != IDLE);
  assign dot.res_valid_o   = (state_q == RESULT);
  assign dot.res_data_o    = acc_q;
  assign dot.res_id_o      = ID_W'(job_q.id);
  assign dot.ovf_o         = ovf_x | ovf_w;

endmodule

// File: tb/tb_cvxif_dot_engine.sv
// Self-checking bench for cvxif_dot_engine: table vectors, directed corner sequences,
// and randomized jobs checked against a queue-based arithmetic model.
module tb_cvxif_dot_engine;
  import cvxif_instr_pkg::*;

  localparam int NB = 151;
  localparam int LN = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cvxif_dot_engine_if bus ();

  cvxif_dot_engine #(
    .NB_REGS (NB),
    .DATA_W  (8),
    .LANES   (LN),
    .ACC_W   (32),
    .ID_W    (3)
  ) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .dot    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  byte unsigned xq[$];
  byte          wq[$];
  bit           ovf_m = 1'b0;

  typedef struct {
    int     xv;
    int     wv;
    int     len;
    int     bias;
    longint exp_data;
    int     exp_lat;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint model(input int len, input int bias);
    longint s = longint'(bias);
    for (int i = 0; i < len; i++) s += longint'(xq[i]) * longint'(wq[i]);
    return longint'(int'(s));
  endfunction

  function automatic int exp_latency(input int len);
    return (len == 0) ? 1 : (len + LN - 1) / LN + 4;
  endfunction

  task automatic wr(input bit is_w, input logic [7:0] d);
    bus.wr_valid_i     = 1'b1;
    bus.wr_is_weight_i = is_w;
    bus.wr_data_i      = d;
    @(negedge clk);
    bus.wr_valid_i = 1'b0;
    if (is_w) begin
      if (wq.size() < NB) wq.push_back(byte'(d)); else ovf_m = 1'b1;
    end else begin
      if (xq.size() < NB) xq.push_back(byte'(d)); else ovf_m = 1'b1;
    end
  endtask

  task automatic start_job(input int len, input int bias, input int id);
    bus.start_valid_i = 1'b1;
    bus.start_len_i   = 8'(len);
    bus.start_bias_i  = 32'(bias);
    bus.start_id_i    = 3'(id);
    @(negedge clk);
    bus.start_valid_i = 1'b0;
  endtask

  task automatic wait_res(input string name, input int max_cyc, output int cyc);
    cyc = 0;
    while (!bus.res_valid_o && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_valid"}, longint'(bus.res_valid_o), 1);
  endtask

  task automatic finish_res(input string name, input longint exp_data, input int exp_id);
    chk({name, "_data"}, longint'($signed(bus.res_data_o)), exp_data);
    chk({name, "_id"}, longint'(bus.res_id_o), exp_id);
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    bus.res_ready_i = 1'b0;
    xq.delete();
    wq.delete();
  endtask

  task automatic run_job(input string name, input int len, input int bias, input int id,
                         input int exp_lat, input longint exp_data);
    int cyc;
    start_job(len, bias, id);
    wait_res(name, 300, cyc);
    chk({name, "_lat"}, cyc + 1, exp_lat);
    finish_res(name, exp_data, id);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int seen;
    longint e;

    bus.clear_i = 0; bus.wr_valid_i = 0; bus.wr_is_weight_i = 0; bus.wr_data_i = '0;
    bus.start_valid_i = 0; bus.start_len_i = '0; bus.start_bias_i = '0; bus.start_id_i = '0;
    bus.kill_i = 0; bus.res_ready_i = 0;

    tbl[0] = '{3,   -2,   8,   100,                     52,          5};
    tbl[1] = '{255, 127,  9,   0,                       291465,      6};
    tbl[2] = '{0,   -1,   5,   -7,                      -7,          5};
    tbl[3] = '{200, -128, 17,  1000,                    -434200,     7};
    tbl[4] = '{1,   1,    151, 0,                       151,         23};
    tbl[5] = '{7,   5,    0,   -12345,                  -12345,      1};
    tbl[6] = '{255, -128, 151, int'(32'h8000_0000),     2142555008,  23};

    repeat (2) @(negedge clk);
    chk("rst_start_ready", longint'(bus.start_ready_o), 1);
    chk("rst_res_valid", longint'(bus.res_valid_o), 0);
    chk("rst_busy", longint'(bus.busy_o), 0);
    chk("rst_ovf", longint'(bus.ovf_o), 0);
    chk("rst_res_data", longint'(bus.res_data_o), 0);
    chk("rst_res_id", longint'(bus.res_id_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < tbl[k].len; i++) begin
        wr(1'b0, 8'(tbl[k].xv));
        wr(1'b1, 8'(tbl[k].wv));
      end
      run_job($sformatf("tbl%0d", k), tbl[k].len, tbl[k].bias, k, tbl[k].exp_lat, tbl[k].exp_data);
    end

    for (int i = 1; i <= 16; i++) begin
      wr(1'b0, 8'(i));
      wr(1'b1, 8'd2);
    end
    run_job("t1", 16, 5, 1, 6, 277);

    wr(1'b0, 8'hFF);
    wr(1'b1, 8'h80);
    run_job("t2", 1, 0, 2, 5, -32640);

    for (int i = 0; i < 16; i++) begin
      if (i < 10) begin wr(1'b0, 8'(i + 1)); wr(1'b1, 8'd3); end
      else        begin wr(1'b0, 8'd99);     wr(1'b1, 8'hCE); end
    end
    run_job("t3_mask", 10, 0, 3, 6, 165);

    wr(1'b0, 8'd10); wr(1'b0, 8'd20); wr(1'b0, 8'd30); wr(1'b0, 8'd40);
    wr(1'b1, 8'd1);  wr(1'b1, 8'd2);
    start_job(4, 0, 4);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.res_valid_o) seen++;
      @(negedge clk);
    end
    chk("t4_stall_no_valid", seen, 0);
    chk("t4_stall_busy", longint'(bus.busy_o), 1);
    wr(1'b1, 8'd3);
    wr(1'b1, 8'd4);
    wait_res("t4", 50, cyc);
    finish_res("t4", 300, 4);

    for (int i = 0; i < 40; i++) begin
      wr(1'b0, 8'(i * 3));
      wr(1'b1, 8'(i - 20));
    end
    start_job(40, 7, 5);
    @(negedge clk);
    bus.kill_i = 1'b1;
    @(negedge clk);
    bus.kill_i = 1'b0;
    chk("t5_kill_idle", longint'(bus.start_ready_o), 1);
    chk("t5_kill_busy", longint'(bus.busy_o), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.res_valid_o) seen++;
      @(negedge clk);
    end
    chk("t5_kill_no_result", seen, 0);
    chk("t5_banks_kept", longint'(u_dut.ptr_x), 40);
    run_job("t5_restart", 40, 7, 5, 9, model(40, 7));

    wr(1'b0, 8'd4); wr(1'b0, 8'd5); wr(1'b0, 8'd6);
    wr(1'b1, 8'hFF); wr(1'b1, 8'd2); wr(1'b1, 8'd3);
    start_job(3, 1, 7);
    wait_res("t5b", 50, cyc);
    bus.kill_i = 1'b1;
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    bus.kill_i = 1'b0;
    bus.res_ready_i = 1'b0;
    chk("t5b_kill_over_hs_busy", longint'(bus.busy_o), 0);
    chk("t5b_kill_keeps_banks", longint'(u_dut.ptr_w), 3);
    run_job("t5b_rerun", 3, 1, 7, 5, model(3, 1));

    for (int i = 0; i < 152; i++) wr(1'b1, 8'(i));
    chk("t6_ovf", longint'(bus.ovf_o), longint'(ovf_m));
    chk("t6_ptr_w", longint'(u_dut.ptr_w), wq.size());
    wr(1'b0, 8'd5); wr(1'b0, 8'd6); wr(1'b0, 8'd7);
    start_job(3, 9, 6);
    wait_res("t6", 50, cyc);
    e = model(3, 9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t6_hold_data%0d", i), longint'($signed(bus.res_data_o)), e);
      chk($sformatf("t6_hold_id%0d", i), longint'(bus.res_id_o), 6);
    end
    finish_res("t6", e, 6);
    chk("t6_ptr_w_after_hs", longint'(u_dut.ptr_w), 0);
    chk("t6_ptr_x_after_hs", longint'(u_dut.ptr_x), 0);
    chk("t6_ovf_kept", longint'(bus.ovf_o), 1);
    bus.clear_i = 1'b1;
    bus.wr_valid_i = 1'b1;
    bus.wr_is_weight_i = 1'b0;
    bus.wr_data_i = 8'd77;
    @(negedge clk);
    bus.clear_i = 1'b0;
    bus.wr_valid_i = 1'b0;
    ovf_m = 1'b0;
    chk("clear_ovf", longint'(bus.ovf_o), 0);
    chk("clear_beats_write", longint'(u_dut.ptr_x), 0);

    for (int j = 0; j < 12; j++) begin
      int len = $urandom_range(0, 45);
      int extra = $urandom_range(0, 6);
      int bias = int'($urandom);
      int id = $urandom_range(0, 7);
      for (int i = 0; i < len + extra; i++) begin
        wr(1'b0, 8'($urandom));
        wr(1'b1, 8'($urandom));
      end
      run_job($sformatf("rnd%0d", j), len, bias, id, exp_latency(len), model(len, bias));
    end

    for (int i = 0; i < 20; i++) begin
      wr(1'b0, 8'(i));
      wr(1'b1, 8'(i));
    end
    start_job(20, 3, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", longint'(bus.res_valid_o), 0);
    chk("midrst_start_ready", longint'(bus.start_ready_o), 1);
    chk("midrst_ptr_x", longint'(u_dut.ptr_x), 0);
    xq.delete();
    wq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr(1'b0, 8'd9);
    wr(1'b1, 8'hFD);
    run_job("post_rst", 1, 0, 2, 5, -27);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
